// File: rtl/ringbuffer_pkg.sv
// Shared ring-buffer constants and sizing helpers.
// Also used by the capture FIFO and the host readout.
package ringbuffer_pkg;

    localparam bit POLICY_DROP      = 1'b0;
    localparam bit POLICY_OVERWRITE = 1'b1;

    function automatic int depth_of(input int bits);
        return 1 << bits;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, so one bit wider than an address.
    function automatic int count_width(input int bits);
        return bits + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a clear.
// A clear and an event in the same cycle leave the count at one.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= {{(W-1){1'b0}}, inc};
        end else if (inc && value != '1) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/ringbuffer_ctrl.sv
// Pointer and occupancy controller for a power-of-two ring buffer.
// Drop-newest or overwrite-oldest when full; sticky errors and drop count.
import ringbuffer_pkg::*;

module ringbuffer_ctrl #(
    parameter int BITS      = 5,
    parameter bit OVERWRITE = POLICY_DROP,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4,
    parameter int DROP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_req,
    input  logic              read_req,
    input  logic              flush,
    input  logic              clear_status,
    output logic              write_accept,
    output logic              read_accept,
    output logic [BITS-1:0]   write_addr,
    output logic [BITS-1:0]   read_addr,
    output logic [BITS:0]     count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int DEPTH = depth_of(BITS);
    localparam int CW    = count_width(BITS);

    logic            live;
    logic            ovw_full;
    logic            rd_adv;
    logic            drop_evt;
    logic            under_evt;
    logic [BITS-1:0] wa_n;
    logic [BITS-1:0] ra_n;
    logic [CW-1:0]   cnt_n;

    assign live         = ~reset & ~flush;
    assign read_accept  = live & read_req & ~empty;
    assign write_accept = live & write_req & (~full | OVERWRITE);

    // Overwrite while full with no read: the oldest entry is pushed out.
    assign ovw_full  = write_accept & full & ~read_accept;
    assign rd_adv    = read_accept | ovw_full;
    assign drop_evt  = live & write_req & full
                     & ~(OVERWRITE & read_accept);
    assign under_evt = live & read_req & empty;

    always_comb begin
        wa_n  = write_addr + BITS'(write_accept);
        ra_n  = read_addr + BITS'(rd_adv);
        cnt_n = count;
        unique case ({write_accept, rd_adv})
            2'b10:   cnt_n = count + 1'b1;
            2'b01:   cnt_n = count - 1'b1;
            default: cnt_n = count;
        endcase
        if (flush) begin
            wa_n  = '0;
            ra_n  = '0;
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_addr   <= '0;
            read_addr    <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            write_addr   <= wa_n;
            read_addr    <= ra_n;
            count        <= cnt_n;
            empty        <= (cnt_n == '0);
            full         <= (cnt_n == CW'(DEPTH));
            almost_full  <= (cnt_n >= CW'(AF_THRESH));
            almost_empty <= (cnt_n <= CW'(AE_THRESH));
            overflow     <= (overflow & ~clear_status) | drop_evt;
            underflow    <= (underflow & ~clear_status) | under_evt;
        end
    end

    sat_counter #(.W(DROP_W)) u_drops (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_evt),
        .clr   (clear_status),
        .value (drop_count)
    );

endmodule
